dispatch_sched: RTL

DISPATCH_SCHED -- requirements
Module: dispatch_sched

---
 rtl/dispatch_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dispatch_sched.sv
// Dual-slot dispatch scheduler. It sits between decode and the issue pipes,
// writes decoded pairs into an external queue and pops up to two packets per
// cycle from the queue head. Slot 1 may only issue alongside slot 0 when the
// pair is independent. A serializing instruction stalls issue until
// serial_done arrives. A flush empties everything in one cycle.
//
// Handshake: decode presents a pair on dec_valid/dec_data. The pair is taken
// on a rising edge where dec_ready && dec_valid[0]. dec_ready does not depend
// on dec_valid. Each issue pipe sees issue_valid[i]. The packet leaves the
// queue when the slot pops. Pipe 0 pops when issue_ready[0]=1, and pipe 1
// additionally needs issue_ready[1]=1. Bubbles pop without needing ready and
// are never presented as valid.
module dispatch_sched #(
    parameter int DATA_WIDTH = 32,  // >= 32
    parameter int DEPTH      = 8    // power of two, >= 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [1:0]                dec_valid,
    input  logic [2*DATA_WIDTH-1:0]   dec_data,
    output logic                      dec_ready,
    output logic [1:0]                fq_enqueue_en,
    output logic [2*DATA_WIDTH-1:0]   fq_enqueue_data,
    input  logic                      fq_full,
    output logic                      fq_flush,
    output logic [1:0]                fq_dqueue_en,
    input  logic [2*DATA_WIDTH-1:0]   fq_dqueue_data,
    output logic [1:0]                fq_invalid_en,
    output logic [1:0]                issue_valid,
    output logic [2*DATA_WIDTH-1:0]   issue_data,
    input  logic [1:0]                issue_ready,
    input  logic                      serial_done,
    output logic [31:0]               dual_issue_cnt,
    output logic [1:0]                dbg_state,
    output logic [$clog2(DEPTH):0]    dbg_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = DATA_WIDTH;

    // Packet field bit positions
    localparam int B_SERIAL = 31;
    localparam int B_P0ONLY = 30;
    localparam int B_RD     = 25;
    localparam int B_RS1    = 20;
    localparam int B_RS2    = 15;
    localparam int B_RDWE   = 14;
    localparam int B_BUBBLE = 13;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SERIAL = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    dual_q, dual_d;

    logic           enq, pop0, pop1, has1, has2, hazard;
    logic           serial0, serial1, p0only1, bubble0, bubble1, rd_we0, rd_we1;
    logic [4:0]     rd0, rd1, rs1_1, rs2_1;

    // Head (slot 0) and head+1 (slot 1) fields
    assign serial0 = fq_dqueue_data[B_SERIAL];
    assign bubble0 = fq_dqueue_data[B_BUBBLE];
    assign rd_we0  = fq_dqueue_data[B_RDWE];
    assign rd0     = fq_dqueue_data[B_RD +: 5];
    assign serial1 = fq_dqueue_data[DW + B_SERIAL];
    assign p0only1 = fq_dqueue_data[DW + B_P0ONLY];
    assign bubble1 = fq_dqueue_data[DW + B_BUBBLE];
    assign rd_we1  = fq_dqueue_data[DW + B_RDWE];
    assign rd1     = fq_dqueue_data[DW + B_RD +: 5];
    assign rs1_1   = fq_dqueue_data[DW + B_RS1 +: 5];
    assign rs2_1   = fq_dqueue_data[DW + B_RS2 +: 5];

    assign has1 = (cnt_q >= CW'(1));
    assign has2 = (cnt_q >= CW'(2));

    // Slot 1 depends on slot 0 (RAW on a source, or WAW on the destination)
    assign hazard = !bubble0 && rd_we0 && (rd0 != 5'd0) &&
                    ((rd0 == rs1_1) || (rd0 == rs2_1) || (rd_we1 && (rd0 == rd1)));

    // Enqueue accept; leaves two free entries so a full pair always fits
    assign dec_ready = !rst && (state_q != FLUSH) && !flush && !fq_full &&
                       (cnt_q <= CW'(DEPTH - 2));
    assign enq = dec_ready && dec_valid[0];

    assign fq_enqueue_en   = {enq, enq};
    assign fq_enqueue_data = rst ? '0 :
                             (dec_valid == 2'b01) ? {DW'(1) << B_BUBBLE, dec_data[DW-1:0]} :
                             dec_data;

    assign fq_flush     = !rst && (flush || (state_q == FLUSH));
    assign fq_dqueue_en = {has2, has1};

    // Pop selection: only in RUN, and never in a flush cycle
    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (!flush && (state_q == RUN)) begin
            pop0 = has1 && (bubble0 || issue_ready[0]);
            pop1 = pop0 && has2 && (bubble1 || issue_ready[1]) &&
                   !serial0 && !serial1 && !p0only1 && !hazard;
        end
    end

    assign fq_invalid_en = {pop1, pop0};
    assign issue_valid   = {pop1 && !bubble1, pop0 && !bubble0};
    assign issue_data    = {issue_valid[1] ? fq_dqueue_data[2*DW-1:DW] : {DW{1'b0}},
                            issue_valid[0] ? fq_dqueue_data[DW-1:0]    : {DW{1'b0}}};

    // Next-state: serial issue waits for commit; flush overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (pop0 && !bubble0 && serial0) state_d = SERIAL;
            SERIAL:  if (serial_done) state_d = RUN;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
        if (flush) state_d = FLUSH;
    end

    // Occupancy and dual-issue statistics next values
    always_comb begin
        cnt_d = cnt_q + (enq ? CW'(2) : CW'(0)) - CW'(pop0) - CW'(pop1);
        if (flush) cnt_d = '0;
        dual_d = dual_q;
        if (issue_valid == 2'b11) dual_d = dual_q + 32'd1;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            dual_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dual_q  <= dual_d;
        end
    end

    assign dual_issue_cnt = dual_q;
    assign dbg_state      = state_q;
    assign dbg_cnt        = cnt_q;

endmodule
